// File: rtl/oclib_uart_rx.sv
// UART 8N1 receiver: line synchronizer, centre-sampling FSM and small
// output FIFO with valid/ready handshake and error pulses.
module oclib_uart_rx #(
    parameter int ClockHz    = 100_000_000,
    parameter int Baud       = 115200,
    parameter int SyncCycles = 2,
    parameter int FifoDepth  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxIn,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       errorFraming,
    output logic       errorOverflow,
    output logic       active
);

    localparam int CyclesPerBit = ClockHz / Baud;
    localparam int HalfBit      = CyclesPerBit / 2;
    localparam int CntW         = $clog2(CyclesPerBit);
    localparam int AddrW        = $clog2(FifoDepth);
    localparam int OccW         = AddrW + 1;

    localparam logic [CntW-1:0] LastCnt = CntW'(CyclesPerBit - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(HalfBit - 1);
    localparam logic [OccW-1:0] FullCnt = OccW'(FifoDepth);

    if (CyclesPerBit < 4) begin : gBadBaud
        $error("oclib_uart_rx: CyclesPerBit must be >= 4");
    end
    if (SyncCycles < 2) begin : gBadSync
        $error("oclib_uart_rx: SyncCycles must be >= 2");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gBadFifo
        $error("oclib_uart_rx: FifoDepth must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Stop,
        Break
    } state_t;

    state_t state;
    state_t stateNext;

    logic [SyncCycles-1:0] syncReg;
    logic [SyncCycles-1:0] fresh;
    logic                  lineSync;
    logic                  armed;
    logic [CntW-1:0]       cnt;
    logic [2:0]            bitIdx;
    logic [7:0]            shiftReg;
    logic                  cntClear;
    logic                  bitShift;
    logic                  pushByte;
    logic                  frameErr;

    assign lineSync = syncReg[SyncCycles-1];

    // fresh marks when the sync chain holds only post-reset samples, so a
    // line held low across reset release is not mistaken for idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncReg <= '1;
            fresh   <= '0;
            armed   <= 1'b0;
        end else begin
            syncReg <= {syncReg[SyncCycles-2:0], rxIn};
            fresh   <= {fresh[SyncCycles-2:0], 1'b1};
            armed   <= armed | (fresh[SyncCycles-1] & lineSync);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= Idle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntClear  = 1'b0;
        bitShift  = 1'b0;
        pushByte  = 1'b0;
        frameErr  = 1'b0;
        unique case (state)
            Idle: begin
                cntClear = 1'b1;
                if (armed && !lineSync) stateNext = Start;
            end
            Start: begin
                if (cnt == HalfCnt) begin
                    cntClear  = 1'b1;
                    stateNext = lineSync ? Idle : Data;
                end
            end
            Data: begin
                if (cnt == LastCnt) begin
                    cntClear = 1'b1;
                    bitShift = 1'b1;
                    if (bitIdx == 3'd7) stateNext = Stop;
                end
            end
            Stop: begin
                if (cnt == LastCnt) begin
                    cntClear = 1'b1;
                    if (lineSync) begin
                        pushByte  = 1'b1;
                        stateNext = Idle;
                    end else begin
                        frameErr  = 1'b1;
                        stateNext = Break;
                    end
                end
            end
            Break: begin
                if (lineSync) stateNext = Idle;
            end
            default: stateNext = Idle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            bitIdx       <= '0;
            shiftReg     <= '0;
            errorFraming <= 1'b0;
            active       <= 1'b0;
        end else begin
            cnt          <= cntClear ? '0 : cnt + CntW'(1);
            errorFraming <= frameErr;
            active       <= (stateNext != Idle);
            if (state == Idle) begin
                bitIdx <= '0;
            end else if (bitShift) begin
                bitIdx   <= bitIdx + 3'd1;
                shiftReg <= {lineSync, shiftReg[7:1]};
            end
        end
    end

    logic [7:0]      mem [FifoDepth];
    logic [AddrW-1:0] wrPtr;
    logic [AddrW-1:0] rdPtr;
    logic [OccW-1:0]  count;
    logic [OccW-1:0]  countNext;
    logic             full;
    logic             pop;
    logic             doPush;

    assign full   = (count == FullCnt);
    assign pop    = rxValid & rxReady;
    assign doPush = pushByte & (!full | pop);
    assign rxData = mem[rdPtr];

    always_comb begin
        countNext = count;
        if (doPush && !pop) begin
            countNext = count + OccW'(1);
        end else if (!doPush && pop) begin
            countNext = count - OccW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem[i] <= '0;
            end
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
            rxValid       <= 1'b0;
            errorOverflow <= 1'b0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= shiftReg;
                wrPtr      <= wrPtr + AddrW'(1);
            end
            if (pop) rdPtr <= rdPtr + AddrW'(1);
            count         <= countNext;
            rxValid       <= (countNext != '0);
            errorOverflow <= pushByte & !doPush;
        end
    end

endmodule

// File: tb/tb_oclib_uart_rx.sv
// Directed bench for oclib_uart_rx: frames in, scoreboard queue,
// monitor pops and compares accepted bytes.
module tb_oclib_uart_rx;

    logic       clock;
    logic       reset;
    logic       rxIn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       errorFraming;
    logic       errorOverflow;
    logic       active;

    int nPass  = 0;
    int nTotal = 0;
    int nFrame = 0;
    int nOver  = 0;
    logic [7:0] expQ[$];

    oclib_uart_rx #(
        .ClockHz(1_000_000),
        .Baud(100_000),
        .SyncCycles(2),
        .FifoDepth(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rxIn(rxIn),
        .rxData(rxData),
        .rxValid(rxValid),
        .rxReady(rxReady),
        .errorFraming(errorFraming),
        .errorOverflow(errorOverflow),
        .active(active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: counts error pulses and checks every accepted byte.
    always @(negedge clock) begin
        if (!reset) begin
            if (errorFraming) nFrame++;
            if (errorOverflow) nOver++;
            if (rxValid && rxReady) begin
                if (expQ.size() == 0) begin
                    nTotal++;
                    $display("FAIL spurious byte: got %02h expected none", rxData);
                end else begin
                    check("rxData", rxData, expQ.pop_front());
                end
            end
        end
    end

    // All stimulus tasks start and end 2ns after a rising edge.
    task automatic hold(input logic v, input int n);
        rxIn = v;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        hold(1'b0, 10);
        for (int i = 0; i < 8; i++) hold(d[i], 10);
        hold(stopBit, 10);
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("drainTimeout", expQ.size(), 0);
    endtask

    int f0;
    int o0;

    initial begin
        reset   = 1'b1;
        rxIn    = 1'b1;
        rxReady = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rstValid", rxValid, 0);
        check("rstData", rxData, 0);
        check("rstFraming", errorFraming, 0);
        check("rstOverflow", errorOverflow, 0);
        check("rstActive", active, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        hold(1'b1, 10);

        // Plain frame
        f0 = nFrame; o0 = nOver;
        expQ.push_back(8'hA5);
        sendFrame(8'hA5, 1'b1);
        hold(1'b1, 10);
        drain();
        check("a5Framing", nFrame - f0, 0);
        check("a5Overflow", nOver - o0, 0);

        // Short low glitch, then a real frame
        f0 = nFrame;
        hold(1'b0, 3);
        hold(1'b1, 20);
        check("glitchActive", active, 0);
        check("glitchValid", rxValid, 0);
        expQ.push_back(8'h3C);
        sendFrame(8'h3C, 1'b1);
        hold(1'b1, 10);
        drain();
        check("glitchFraming", nFrame - f0, 0);

        // Framing error with break
        f0 = nFrame;
        sendFrame(8'h55, 1'b0);
        hold(1'b0, 50);
        check("breakActive", active, 1);
        hold(1'b1, 20);
        check("breakIdle", active, 0);
        check("breakFraming", nFrame - f0, 1);
        check("breakValid", rxValid, 0);
        expQ.push_back(8'h81);
        sendFrame(8'h81, 1'b1);
        hold(1'b1, 10);
        drain();

        // Overflow with consumer stalled
        o0 = nOver;
        rxReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expQ.push_back(8'(i));
            sendFrame(8'(i), 1'b1);
            hold(1'b1, 3);
        end
        check("ovfBefore5", nOver - o0, 0);
        sendFrame(8'h05, 1'b1);
        hold(1'b1, 5);
        check("ovfOn5", nOver - o0, 1);
        check("ovfStallData", rxData, 8'h01);
        rxReady = 1'b1;
        drain();
        hold(1'b1, 3);
        check("ovfEmpty", rxValid, 0);

        // Back-to-back frames
        f0 = nFrame; o0 = nOver;
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        sendFrame(8'h00, 1'b1);
        sendFrame(8'hFF, 1'b1);
        hold(1'b1, 10);
        drain();
        check("b2bFraming", nFrame - f0, 0);
        check("b2bOverflow", nOver - o0, 0);

        // Reset mid-frame with one byte queued
        rxReady = 1'b0;
        sendFrame(8'h11, 1'b1);
        hold(1'b1, 5);
        check("queuedValid", rxValid, 1);
        hold(1'b0, 10);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b1, 10);
        hold(1'b1, 10);
        hold(1'b1, 5);
        reset = 1'b1;
        rxIn  = 1'b1;
        @(negedge clock);
        check("midRstValid", rxValid, 0);
        check("midRstData", rxData, 0);
        check("midRstActive", active, 0);
        check("midRstFraming", errorFraming, 0);
        check("midRstOverflow", errorOverflow, 0);
        @(posedge clock);
        #2;
        reset   = 1'b0;
        rxReady = 1'b1;
        hold(1'b1, 20);
        check("postRstValid", rxValid, 0);
        check("postRstActive", active, 0);
        expQ.push_back(8'hC3);
        sendFrame(8'hC3, 1'b1);
        hold(1'b1, 10);
        drain();
        hold(1'b1, 30);
        check("finalValid", rxValid, 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
